// File: rtl/rv32i_types.sv
// Shared RV32I types and memory-side constants.
// Line/burst widths used by the cacheline adapter live here.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef logic [255:0] cacheline_t;
    typedef logic [63:0]  burst_t;

    localparam int BURST_LEN = 4;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } adapter_state_t;

    // Lines are 32 bytes, so memory only ever sees line-aligned addresses.
    function automatic rv32i_word line_align(input rv32i_word a);
        return {a[31:5], 5'b0};
    endfunction

endpackage

// File: rtl/cacheline_adapter.sv
// Splits one cacheline read/write into a 4-beat memory burst.
// Line data is buffered both ways; arbiter gets a 1-cycle resp.
module cacheline_adapter
    import rv32i_types::*;
#(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   read_i,
    input  logic                   write_i,
    input  logic [31:0]            address_i,
    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    output logic                   resp_o,

    input  logic [BURST_WIDTH-1:0] burst_i,
    input  logic                   resp_i,
    output logic [BURST_WIDTH-1:0] burst_o,
    output logic [31:0]            address_o,
    output logic                   read_o,
    output logic                   write_o
);

    localparam int CNT_W = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    adapter_state_t        state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [LINE_WIDTH-1:0] buf_q, buf_d;
    logic [LINE_WIDTH-1:0] line_q, line_d;
    rv32i_word             addr_q, addr_d;
    logic                  last_beat;

    assign last_beat = resp_i && (count_q == LAST_BEAT);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        buf_d   = buf_q;
        line_d  = line_q;
        addr_d  = addr_q;

        unique case (state_q)
            IDLE: begin
                if (write_i) begin
                    buf_d   = line_i;
                    addr_d  = line_align(address_i);
                    count_d = '0;
                    state_d = WRITE;
                end else if (read_i) begin
                    addr_d  = line_align(address_i);
                    count_d = '0;
                    state_d = READ;
                end
            end
            READ: begin
                if (resp_i) begin
                    buf_d[count_q*BURST_WIDTH +: BURST_WIDTH] = burst_i;
                    count_d = count_q + 1'b1;
                end
                // Publish the full line only when the last beat lands.
                if (last_beat) begin
                    line_d  = buf_d;
                    state_d = DONE;
                end
            end
            WRITE: begin
                if (resp_i) begin
                    count_d = count_q + 1'b1;
                end
                if (last_beat) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            buf_q   <= '0;
            line_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            buf_q   <= buf_d;
            line_q  <= line_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        read_o    = 1'b0;
        write_o   = 1'b0;
        resp_o    = 1'b0;
        burst_o   = '0;
        address_o = addr_q;
        line_o    = line_q;

        unique case (state_q)
            READ: begin
                read_o = 1'b1;
            end
            WRITE: begin
                write_o = 1'b1;
                burst_o = buf_q[count_q*BURST_WIDTH +: BURST_WIDTH];
            end
            DONE: begin
                resp_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
